// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared FSM state type and default sizing for period_meter
package period_meter_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } state_t;

   // Defaults shared with clock divider instances
   localparam int DEFAULT_COUNTER_SIZE = 24;
   localparam int DEFAULT_TIMEOUT      = 12000000;
   localparam int DEFAULT_SYNC_STAGES  = 2;

endpackage

// File: rtl/period_meter_edge_sync.sv
// rtl/period_meter_edge_sync.sv - signal_in synchroniser chain with rise/fall detection
module edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clock_in,
   input  logic reset_n,
   input  logic signal_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   prev_r;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         sync_r <= '0;
         prev_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], signal_in};
         prev_r <= sync_r[SYNC_STAGES-1];
      end
   end

   assign level = sync_r[SYNC_STAGES-1];
   assign rise  = level & ~prev_r;
   assign fall  = ~level & prev_r;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures signal_in period in clock_in cycles with timeout
// Optional high-phase measurement enabled by defining PERIOD_METER_DUTY_EN.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
   parameter int TIMEOUT      = DEFAULT_TIMEOUT,
   parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
   input  logic                    clock_in,
   input  logic                    reset_n,
   input  logic                    signal_in,
   output logic [COUNTER_SIZE-1:0] period_out,
   output logic                    period_valid,
   output logic                    timeout,
   output logic [COUNTER_SIZE-1:0] high_time_out
);

   localparam logic [COUNTER_SIZE-1:0] TIMEOUT_CNT = COUNTER_SIZE'(TIMEOUT);
   localparam logic [COUNTER_SIZE-1:0] ONE         = COUNTER_SIZE'(1);

   logic                    level;
   logic                    rise;
   logic                    fall;
   state_t                  state;
   logic [COUNTER_SIZE-1:0] count;

   edge_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_edge_sync (
      .clock_in  (clock_in),
      .reset_n   (reset_n),
      .signal_in (signal_in),
      .level     (level),
      .rise      (rise),
      .fall      (fall)
   );

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         count        <= '0;
         period_out   <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               count <= '0;
               // First edge only arms the measurement; there is no prior edge to measure from
               if (rise) begin
                  state   <= ST_MEASURE;
                  count   <= ONE;
                  timeout <= 1'b0;
               end
            end
            ST_MEASURE: begin
               // An edge landing exactly on the limit still counts as a valid period
               if (rise) begin
                  period_out   <= count;
                  period_valid <= 1'b1;
                  count        <= ONE;
               end else if (count == TIMEOUT_CNT) begin
                  timeout <= 1'b1;
                  state   <= ST_IDLE;
                  count   <= '0;
               end else begin
                  count <= count + ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef PERIOD_METER_DUTY_EN
   logic [COUNTER_SIZE-1:0] high_count;
   logic [COUNTER_SIZE-1:0] high_latch;
   logic [COUNTER_SIZE-1:0] high_time_r;

   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         high_count  <= '0;
         high_latch  <= '0;
         high_time_r <= '0;
      end else begin
         // The rise cycle itself is the first high cycle of the period
         if (rise) begin
            high_count <= ONE;
         end else if (state == ST_MEASURE && level) begin
            high_count <= high_count + ONE;
         end
         if (fall) begin
            high_latch <= high_count;
         end
         if (state == ST_MEASURE && rise) begin
            high_time_r <= high_latch;
         end
      end
   end

   assign high_time_out = high_time_r;
`else
   logic unused_sync;
   assign unused_sync   = ^{level, fall};
   assign high_time_out = '0;
`endif

endmodule
